// File: rtl/zeroriscy_cg_pkg.sv
// Shared types and constants for the core clock-gating sequencer.
package zeroriscy_cg_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      IDLE_WAIT = 2'd1,
      GATED     = 2'd2,
      WAKE      = 2'd3
   } cg_state_e;

   localparam int unsigned CG_CNT_W   = 8;
   localparam int unsigned CG_CYC_MIN = 1;
   localparam int unsigned CG_CYC_MAX = 255;

endpackage

// File: rtl/zeroriscy_cg_counter.sv
// Loadable window down-counter; holds at 1 so is_one stays valid until reloaded.
module zeroriscy_cg_counter
   import zeroriscy_cg_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic [CG_CNT_W-1:0] load_val_i,
   input  logic                dec_i,
   output logic                is_one_o
);

   logic [CG_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q > CG_CNT_W'(1))) begin
         cnt_q <= cnt_q - CG_CNT_W'(1);
      end
   end

   assign is_one_o = (cnt_q == CG_CNT_W'(1));

endmodule

// File: rtl/zeroriscy_cg_ctrl.sv
// Sleep/wake sequencer driving the core clock-gate enable.
// Optional gated-cycle statistics counter: define ZERORISCY_CG_STATS_EN.
module zeroriscy_cg_ctrl
   import zeroriscy_cg_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned IDLE_CYCLES = 8,
   parameter int unsigned WAKE_CYCLES = 2,
   parameter int unsigned STAT_W      = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               sleep_req_i,
   input  logic               core_idle_i,
   input  logic [NUM_REQ-1:0] keep_on_i,
   input  logic               wake_i,
   input  logic               test_en_i,
`ifdef ZERORISCY_CG_STATS_EN
   input  logic               stat_clr_i,
   output logic [STAT_W-1:0]  gated_cycles_o,
`endif
   output logic               clock_en_o,
   output logic               sleep_ack_o,
   output logic               wake_done_o,
   output logic [1:0]         state_o
);

   if (IDLE_CYCLES < CG_CYC_MIN || IDLE_CYCLES > CG_CYC_MAX) begin : g_bad_idle
      $error("zeroriscy_cg_ctrl: IDLE_CYCLES out of range 1..255");
   end
   if (WAKE_CYCLES < CG_CYC_MIN || WAKE_CYCLES > CG_CYC_MAX) begin : g_bad_wake
      $error("zeroriscy_cg_ctrl: WAKE_CYCLES out of range 1..255");
   end
   if (NUM_REQ < 1) begin : g_bad_req
      $error("zeroriscy_cg_ctrl: NUM_REQ must be at least 1");
   end

   cg_state_e           state_q, state_d;
   logic                en_q, ack_q, done_q;
   logic                keep_any, qual, wake_cond;
   logic                cnt_load, cnt_dec, cnt_is_one;
   logic [CG_CNT_W-1:0] cnt_load_val;

   assign keep_any  = |keep_on_i;
   assign qual      = sleep_req_i & core_idle_i & ~keep_any & ~wake_i;
   assign wake_cond = wake_i | keep_any | ~sleep_req_i;

   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      case (state_q)
         RUN: begin
            if (qual) begin
               state_d      = IDLE_WAIT;
               cnt_load     = 1'b1;
               cnt_load_val = CG_CNT_W'(IDLE_CYCLES);
            end
         end
         IDLE_WAIT: begin
            cnt_dec = 1'b1;
            if (!qual)           state_d = RUN;
            else if (cnt_is_one) state_d = GATED;
         end
         GATED: begin
            if (wake_cond) begin
               state_d      = WAKE;
               cnt_load     = 1'b1;
               cnt_load_val = CG_CNT_W'(WAKE_CYCLES);
            end
         end
         WAKE: begin
            cnt_dec = 1'b1;
            if (cnt_is_one) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as state_o.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         en_q    <= 1'b1;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= (state_d != GATED);
         ack_q   <= (state_d == GATED);
         done_q  <= (state_q == WAKE) && (state_d == RUN);
      end
   end

   zeroriscy_cg_counter u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .is_one_o   (cnt_is_one)
   );

`ifdef ZERORISCY_CG_STATS_EN
   logic [STAT_W-1:0] gated_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || stat_clr_i) begin
         gated_cnt_q <= '0;
      end else if ((state_q == GATED) && !(&gated_cnt_q)) begin
         gated_cnt_q <= gated_cnt_q + STAT_W'(1);
      end
   end

   assign gated_cycles_o = gated_cnt_q;
`endif

   assign clock_en_o  = en_q | test_en_i;
   assign sleep_ack_o = ack_q;
   assign wake_done_o = done_q;
   assign state_o     = state_q;

endmodule
